// File: rtl/mult_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : mult_seq_pkg
// Purpose  : Shared types and helpers for the digit-serial multiplier.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest operand abs_mag can handle; callers zero-extend into this.
  localparam int c_max_width = 512;

  function automatic int calc_n(input int width, input int digit);
    return (width / digit < 1) ? 1 : width / digit;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Magnitude of a width-bit value; the most negative value maps to 2^(width-1).
  function automatic logic [c_max_width-1:0] abs_mag(
    input logic [c_max_width-1:0] value,
    input int                     width,
    input logic                   is_signed
  );
    logic [c_max_width-1:0] mask;
    logic [c_max_width-1:0] result;
    logic                   msb;
    mask   = {c_max_width{1'b1}} >> (c_max_width - width);
    msb    = |(value & mask & ~(mask >> 1));
    result = value & mask;
    if (is_signed && msb) begin
      result = (~value + 1'b1) & mask;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_pp_digit.sv
//------------------------------------------------------------------------------
// Module   : mult_pp_digit
// Purpose  : Combinational WIDTH x DIGIT unsigned partial product.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_pp_digit #(
  parameter int WIDTH = 128,
  parameter int DIGIT = 32
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [DIGIT-1:0]       b,
  output logic [WIDTH+DIGIT-1:0] p
);

  localparam int c_pw = WIDTH + DIGIT;

  assign p = c_pw'(a) * c_pw'(b);

endmodule

`default_nettype wire

// File: rtl/multiplier_seq.sv
//------------------------------------------------------------------------------
// Module   : multiplier_seq
// Purpose  : Digit-serial signed/unsigned multiplier, WIDTH/DIGIT cycles/op.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multiplier_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int DIGIT     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] out
);

  localparam int c_n     = calc_n(WIDTH, DIGIT);
  localparam int c_cnt_w = cnt_width(c_n);
  localparam int c_acc_w = 2 * WIDTH;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);

  localparam logic [1:0] c_st_idle = IDLE;
  localparam logic [1:0] c_st_run  = RUN;
  localparam logic [1:0] c_st_done = DONE;

  logic [1:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_mag1;
  logic [WIDTH-1:0]   r_mag2;
  logic               r_sign;
  logic [c_acc_w-1:0] r_acc;
  logic [c_acc_w-1:0] r_out;

  logic               w_mode;
  logic               w_accept;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic               w_sign;
  logic [WIDTH+DIGIT-1:0] w_pp;
  logic [c_acc_w-1:0] w_pp_al;
  logic [c_acc_w-1:0] w_acc_next;
  logic [c_acc_w-1:0] w_prod;

  generate
    if (SIGNED_EN) begin : g_signed
      assign w_mode = signed_mode;
    end else begin : g_unsigned
      logic w_unused_mode;
      assign w_unused_mode = signed_mode;
      assign w_mode        = 1'b0;
    end
  endgenerate

  assign w_accept = start && (r_state == c_st_idle || r_state == c_st_done);
  assign w_mag1   = WIDTH'(abs_mag(c_max_width'(in1), WIDTH, w_mode));
  assign w_mag2   = WIDTH'(abs_mag(c_max_width'(in2), WIDTH, w_mode));
  assign w_sign   = w_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);

  // r_mag2 is shifted down each step, so its low digit is always the current one.
  mult_pp_digit #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_pp (
    .a (r_mag1),
    .b (r_mag2[DIGIT-1:0]),
    .p (w_pp)
  );

  assign w_pp_al    = c_acc_w'(w_pp) << (32'(r_cnt) * 32'(DIGIT));
  assign w_acc_next = r_acc + w_pp_al;
  assign w_prod     = r_sign ? -w_acc_next : w_acc_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_mag1  <= '0;
      r_mag2  <= '0;
      r_sign  <= 1'b0;
      r_acc   <= '0;
      r_out   <= '0;
    end else if (w_accept) begin
      r_state <= c_st_run;
      r_cnt   <= '0;
      r_mag1  <= w_mag1;
      r_mag2  <= w_mag2;
      r_sign  <= w_sign;
      r_acc   <= '0;
    end else if (r_state == c_st_run) begin
      r_acc  <= w_acc_next;
      r_mag2 <= r_mag2 >> DIGIT;
      if (r_cnt == c_last) begin
        r_out   <= w_prod;
        r_state <= c_st_done;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign busy  = (r_state == c_st_run);
  assign ready = (r_state == c_st_done);
  assign out   = r_out;

endmodule

`default_nettype wire

// File: tb/tb_multiplier_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_multiplier_seq
// Purpose  : Self-checking bench for three multiplier_seq configurations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multiplier_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;

  logic         start_v [3];
  logic         sm_v    [3];
  logic [127:0] in1_v   [3];
  logic [127:0] in2_v   [3];
  logic         busy_v  [3];
  logic         ready_v [3];
  logic [255:0] out0;
  logic [15:0]  out1;
  logic [31:0]  out2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // dut 0: 128/32, dut 1: 8/2, dut 2: 16/16
  multiplier_seq #(.WIDTH(128), .DIGIT(32), .SIGNED_EN(1'b1)) u_dut0 (
    .clock(clk), .reset_n(rst_n), .start(start_v[0]), .signed_mode(sm_v[0]),
    .in1(in1_v[0]), .in2(in2_v[0]), .busy(busy_v[0]), .ready(ready_v[0]), .out(out0));
  multiplier_seq #(.WIDTH(8), .DIGIT(2), .SIGNED_EN(1'b1)) u_dut1 (
    .clock(clk), .reset_n(rst_n), .start(start_v[1]), .signed_mode(sm_v[1]),
    .in1(in1_v[1][7:0]), .in2(in2_v[1][7:0]), .busy(busy_v[1]), .ready(ready_v[1]), .out(out1));
  multiplier_seq #(.WIDTH(16), .DIGIT(16), .SIGNED_EN(1'b1)) u_dut2 (
    .clock(clk), .reset_n(rst_n), .start(start_v[2]), .signed_mode(sm_v[2]),
    .in1(in1_v[2][15:0]), .in2(in2_v[2][15:0]), .busy(busy_v[2]), .ready(ready_v[2]), .out(out2));

  function automatic int w_of(input int d);
    return (d == 0) ? 128 : (d == 1) ? 8 : 16;
  endfunction

  function automatic int n_of(input int d);
    return (d == 2) ? 1 : 4;
  endfunction

  function automatic logic [255:0] get_out(input int d);
    return (d == 0) ? out0 : (d == 1) ? 256'(out1) : 256'(out2);
  endfunction

  // Plain arithmetic reference: sign-extend to 256 bits, multiply, keep 2w bits.
  function automatic logic [255:0] golden(input logic [127:0] a, input logic [127:0] b,
                                          input int w, input bit sgn);
    logic [255:0] m1, m2, ea, eb;
    m1 = (256'(1) << w) - 1;
    m2 = (256'(1) << (2 * w)) - 1;
    ea = 256'(a) & m1;
    eb = 256'(b) & m1;
    if (sgn && ea[w-1]) ea = ea | ~m1;
    if (sgn && eb[w-1]) eb = eb | ~m1;
    return (ea * eb) & m2;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: cycles remaining per unit plus the result waiting to appear.
  int           m_rem   [3];
  logic         m_busy  [3];
  logic         m_ready [3];
  logic [255:0] m_out   [3];
  logic [255:0] m_pend  [3];

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_rem[d] = 0; m_busy[d] = 0; m_ready[d] = 0; m_out[d] = '0; m_pend[d] = '0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 3; d++) begin
        if (!rst_n) begin
          m_rem[d] = 0; m_busy[d] = 0; m_ready[d] = 0; m_out[d] = '0;
        end else if (m_rem[d] == 0) begin
          if (start_v[d] === 1'b1) begin
            m_rem[d]   = n_of(d);
            m_busy[d]  = 1'b1;
            m_ready[d] = 1'b0;
            m_pend[d]  = golden(in1_v[d], in2_v[d], w_of(d), sm_v[d]);
          end
        end else begin
          m_rem[d] = m_rem[d] - 1;
          if (m_rem[d] == 0) begin
            m_busy[d]  = 1'b0;
            m_ready[d] = 1'b1;
            m_out[d]   = m_pend[d];
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("busy%0d", d), 256'(busy_v[d]), 256'(m_busy[d]));
          chk($sformatf("ready%0d", d), 256'(ready_v[d]), 256'(m_ready[d]));
          chk($sformatf("out%0d", d), get_out(d), m_out[d]);
        end
      end
    end
  end

  task automatic go(input int d, input logic [127:0] a, input logic [127:0] b, input logic sm);
    in1_v[d] = a; in2_v[d] = b; sm_v[d] = sm; start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  task automatic wait_ready(input int d, input int exp_lat, input string name);
    int c = 0;
    while (ready_v[d] !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk(name, 256'(c), 256'(exp_lat));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int last, pulses;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 0; sm_v[d] = 0; in1_v[d] = '0; in2_v[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("rst_busy", 256'(busy_v[0]), 256'(0));
    chk("rst_ready", 256'(ready_v[0]), 256'(0));
    chk("rst_out", out0, 256'(0));

    // Full-width unsigned all-ones
    go(0, {128{1'b1}}, {128{1'b1}}, 1'b0);
    chk("busy_after_accept", 256'(busy_v[0]), 256'(1));
    wait_ready(0, 4, "lat_128");
    chk("allones_out", out0, {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h1});
    chk("allones_model", m_out[0], {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h1});

    // Back-to-back with start held; operands churn every cycle including during RUN
    last = -1; pulses = 0;
    start_v[0] = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      in1_v[0] = {$urandom, $urandom, $urandom, $urandom};
      in2_v[0] = {$urandom, $urandom, $urandom, $urandom};
      sm_v[0]  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ready_v[0] === 1'b1) begin
        if (last >= 0) chk("b2b_gap", 256'(cyc - last), 256'(5));
        last = cyc;
        pulses++;
      end
    end
    start_v[0] = 1'b0;
    chk("b2b_pulses", 256'(pulses), 256'(8));

    // Asynchronous reset in the middle of RUN
    go(0, {128{1'b1}}, 128'h3, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 256'(busy_v[0]), 256'(0));
    chk("arst_ready", 256'(ready_v[0]), 256'(0));
    chk("arst_out", out0, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_rst", 256'(busy_v[0]), 256'(0));
    end

    // Signed corner cases on the 8-bit unit
    go(1, 128'h80, 128'h80, 1'b1);
    wait_ready(1, 4, "lat_8");
    chk("s_80x80", 256'(out1), 256'h4000);
    go(1, 128'h80, 128'h01, 1'b1);
    wait_ready(1, 4, "lat_8b");
    chk("s_80x01", 256'(out1), 256'hFF80);
    go(1, 128'h80, 128'h01, 1'b0);
    wait_ready(1, 4, "lat_8c");
    chk("u_80x01", 256'(out1), 256'h0080);

    // Inputs and start wiggle during RUN
    go(1, 128'h05, 128'h07, 1'b0);
    in1_v[1] = 128'h55; in2_v[1] = 128'h33; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    @(negedge clk);
    in1_v[1] = 128'hFF; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    wait_ready(1, 1, "lat_midrun");
    chk("midrun_out", 256'(out1), 256'h0023);

    // Zero operands, signed, never negative
    go(1, 128'h0, 128'hEF, 1'b1);
    wait_ready(1, 4, "lat_zero8");
    chk("zero8_out", 256'(out1), 256'h0);
    go(0, 128'h0, 128'hDEADBEEF, 1'b1);
    wait_ready(0, 4, "lat_zero128");
    chk("zero128_out", out0, 256'h0);

    // Single-digit unit
    go(2, 128'hFFFF, 128'h0002, 1'b0);
    wait_ready(2, 1, "lat_n1");
    chk("n1_out", 256'(out2), 256'h0001FFFE);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
